// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states and BCD display limits.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_MAX    = 9999;
  // A 14-bit input reaches 16383, so the accumulator needs a fifth digit.
  localparam int unsigned ACC_DIGITS = 5;
  localparam int unsigned ACC_W      = ACC_DIGITS * DIGIT_W;
  localparam int unsigned CODE_W     = BCD_DIGITS * DIGIT_W;

  localparam logic [CODE_W-1:0] CLAMP_CODE = 16'h9999;

endpackage

// File: rtl/bin2bcd_seq_add3_digit.sv
// One BCD digit correction step of the shift-and-add-3 algorithm.
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5)
      adjusted = digit + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-8421 BCD converter, one input bit per cycle, start/busy/done handshake.
// Define BIN2BCD_CLAMP_EN to show 9999 for values above MAX_VAL instead of the low four digits.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BIN_W-1:0]   bin_in,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [CODE_W-1:0]  seg_8421_code,
  output logic               ovf
);

  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam bit DIGIT_TEST = (MAX_VAL == int'(BCD_MAX));

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               big;
  logic               over;

  for (genvar g = 0; g < int'(ACC_DIGITS); g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit    (acc[g*DIGIT_W +: DIGIT_W]),
      .adjusted (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // With the 4-digit display limit the fifth BCD digit alone flags overflow;
  // any other limit falls back to a compare captured with the input.
  always_comb begin
    over = big;
    if (DIGIT_TEST)
      over = (acc[ACC_W-1 -: DIGIT_W] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      seg_8421_code <= '0;
      ovf           <= 1'b0;
      shreg         <= '0;
      acc           <= '0;
      cnt           <= '0;
      big           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= bin_in;
            acc   <= '0;
            cnt   <= '0;
            big   <= (32'(bin_in) > 32'(MAX_VAL));
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc   <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          busy  <= 1'b1;
          if (cnt == LAST_SHIFT)
            state <= ST_DONE;
        end
        ST_DONE: begin
`ifdef BIN2BCD_CLAMP_EN
          seg_8421_code <= over ? CLAMP_CODE : acc[CODE_W-1:0];
`else
          seg_8421_code <= acc[CODE_W-1:0];
`endif
          ovf   <= over;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver pushes expected results, monitor checks on done.
module tb_bin2bcd_seq;

  typedef struct {
    logic [15:0] code;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] bin_in = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] seg_8421_code;
  logic        ovf;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        sb[$];
  logic [15:0] held_code = '0;
  logic        held_ovf = 1'b0;
  logic        prev_done = 1'b0;

  bin2bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bin_in        (bin_in),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .seg_8421_code (seg_8421_code),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by plain division, clamped or truncated to four digits.
  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned shown;
    e.ovf = (v > 9999);
    shown = v % 10000;
`ifdef BIN2BCD_CLAMP_EN
    if (e.ovf) shown = 9999;
`endif
    e.code = 16'((shown / 1000) * 4096 + ((shown / 100) % 10) * 256 +
                 ((shown / 10) % 10) * 16 + (shown % 10));
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_code = '0;
      held_ovf  = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("digit_range",
            ((seg_8421_code[15:12] <= 9) && (seg_8421_code[11:8] <= 9) &&
             (seg_8421_code[7:4] <= 9) && (seg_8421_code[3:0] <= 9)) ? 1 : 0, 1);
      if (done) begin
        check("done_single_cycle", prev_done ? 1 : 0, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result_code", seg_8421_code, e.code);
          check("result_ovf", ovf, e.ovf);
          held_code = e.code;
          held_ovf  = e.ovf;
        end
      end else begin
        check("held_code", seg_8421_code, held_code);
        check("held_ovf", ovf, held_ovf);
      end
      prev_done = done;
    end
  end

  // Called off-edge; start is sampled at the next posedge.
  task automatic run_conv(input int unsigned v, input bit check_timing);
    int lat = 0;
    int busy_cycles = 0;
    bit seen = 0;
    bin_in = 14'(v);
    start  = 1'b1;
    sb.push_back(model(v));
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = 14'($urandom);
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (check_timing) begin
      check("done_latency", lat, 15);
      check("busy_cycles", busy_cycles, 14);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_code", seg_8421_code, 0);
    check("reset_ovf", ovf, 0);

    run_conv(1234, 1);
    run_conv(0, 1);
    run_conv(9999, 1);
    run_conv(12345, 1);
    run_conv(10000, 0);
    run_conv(16383, 0);

    // Second start five edges into a conversion must be ignored.
    @(negedge clk);
    bin_in = 14'd42;
    start  = 1'b1;
    sb.push_back(model(42));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bin_in = 14'd77;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    check("ignored_start_drained", sb.size(), 0);

    // Reset sampled at the edge of the seventh shift discards the conversion.
    @(negedge clk);
    bin_in = 14'd500;
    start  = 1'b1;
    sb.push_back(model(500));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_code", seg_8421_code, 0);
    check("midreset_ovf", ovf, 0);
    repeat (25) @(posedge clk);

    @(negedge clk);
    for (int i = 0; i < 40; i++)
      run_conv($urandom_range(0, 16383), 1);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
